// File: rtl/y86_pkg.sv
// Y86-64 architectural constants shared by every pipeline stage.
package y86_pkg;

  typedef enum logic [3:0] {
    AOK = 4'h1,
    HLT = 4'h2,
    ADR = 4'h3,
    INS = 4'h4
  } stat_t;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] RNONE  = 4'hF;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Y86-64 inter-stage pipeline register with stall/bubble control,
// activity counters, stall watchdog and stall/bubble conflict flag.
module pipe_stage_reg
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned REG_W       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STALL_LIMIT = 8,
  parameter logic [3:0]  BUB_ICODE   = I_NOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              bubble,
  input  logic [3:0]        in_status,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [REG_W-1:0]  in_rA,
  input  logic [REG_W-1:0]  in_rB,
  input  logic [DATA_W-1:0] in_valC,
  input  logic [DATA_W-1:0] in_valP,
  input  logic [DATA_W-1:0] in_valA,
  input  logic [DATA_W-1:0] in_valB,
  output logic [3:0]        out_status,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [REG_W-1:0]  out_rA,
  output logic [REG_W-1:0]  out_rB,
  output logic [DATA_W-1:0] out_valC,
  output logic [DATA_W-1:0] out_valP,
  output logic [DATA_W-1:0] out_valA,
  output logic [DATA_W-1:0] out_valB,
  output logic              out_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              stall_timeout,
  output logic              ctrl_err
);

  localparam int unsigned      RUN_W   = $clog2(STALL_LIMIT) + 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);

  logic             stallOnly;
  logic [RUN_W-1:0] runLen;
  logic [RUN_W-1:0] nextRun;

  assign stallOnly = stall & ~bubble;

  always_comb begin
    nextRun = runLen;
    if (runLen != RUN_MAX) begin
      nextRun = runLen + 1'b1;
    end
  end

  // Bubble reuses the reset image of the fields; counters/flags are handled apart.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      out_status <= AOK;
      out_icode  <= BUB_ICODE;
      out_ifun   <= '0;
      out_rA     <= REG_W'(RNONE);
      out_rB     <= REG_W'(RNONE);
      out_valC   <= '0;
      out_valP   <= '0;
      out_valA   <= '0;
      out_valB   <= '0;
      out_valid  <= 1'b0;
    end else if (!stall) begin
      out_status <= in_status;
      out_icode  <= in_icode;
      out_ifun   <= in_ifun;
      out_rA     <= in_rA;
      out_rB     <= in_rB;
      out_valC   <= in_valC;
      out_valP   <= in_valP;
      out_valA   <= in_valA;
      out_valB   <= in_valB;
      out_valid  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      runLen        <= '0;
      stall_timeout <= 1'b0;
      ctrl_err      <= 1'b0;
    end else begin
      if (stall && bubble) begin
        ctrl_err <= 1'b1;
      end
      if (stallOnly) begin
        runLen <= nextRun;
        if (nextRun == RUN_MAX) begin
          stall_timeout <= 1'b1;
        end
      end else begin
        runLen <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stallOnly),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uBubbleCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance plus a CNT_W=2 instance.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, bubble;
  logic        reset2, stall2, bubble2;
  logic [3:0]  in_status, in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC, in_valP, in_valA, in_valB;

  logic [3:0]  out_status, out_icode, out_ifun, out_rA, out_rB;
  logic [63:0] out_valC, out_valP, out_valA, out_valB;
  logic        out_valid, stall_timeout, ctrl_err;
  logic [15:0] stall_cnt, bubble_cnt;

  logic [3:0]  o2Status, o2Icode, o2Ifun, o2RA, o2RB;
  logic [63:0] o2ValC, o2ValP, o2ValA, o2ValB;
  logic        o2Valid, o2Timeout, o2CtrlErr;
  logic [1:0]  o2StallCnt, o2BubbleCnt;

  int unsigned total = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .REG_W(4), .CNT_W(16), .STALL_LIMIT(8), .BUB_ICODE(4'h1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
    .in_status(in_status), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB),
    .in_valC(in_valC), .in_valP(in_valP), .in_valA(in_valA), .in_valB(in_valB),
    .out_status(out_status), .out_icode(out_icode), .out_ifun(out_ifun),
    .out_rA(out_rA), .out_rB(out_rB),
    .out_valC(out_valC), .out_valP(out_valP), .out_valA(out_valA), .out_valB(out_valB),
    .out_valid(out_valid), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .stall_timeout(stall_timeout), .ctrl_err(ctrl_err)
  );

  pipe_stage_reg #(.DATA_W(64), .REG_W(4), .CNT_W(2), .STALL_LIMIT(8), .BUB_ICODE(4'h1)) dut2 (
    .clk(clk), .reset(reset2), .stall(stall2), .bubble(bubble2),
    .in_status(in_status), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB),
    .in_valC(in_valC), .in_valP(in_valP), .in_valA(in_valA), .in_valB(in_valB),
    .out_status(o2Status), .out_icode(o2Icode), .out_ifun(o2Ifun),
    .out_rA(o2RA), .out_rB(o2RB),
    .out_valC(o2ValC), .out_valP(o2ValP), .out_valA(o2ValA), .out_valB(o2ValB),
    .out_valid(o2Valid), .stall_cnt(o2StallCnt), .bubble_cnt(o2BubbleCnt),
    .stall_timeout(o2Timeout), .ctrl_err(o2CtrlErr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkResetImage(input string tag);
    chk({tag, ".status"}, 64'(out_status), 64'h1);
    chk({tag, ".icode"},  64'(out_icode),  64'h1);
    chk({tag, ".ifun"},   64'(out_ifun),   64'h0);
    chk({tag, ".rA"},     64'(out_rA),     64'hF);
    chk({tag, ".rB"},     64'(out_rB),     64'hF);
    chk({tag, ".valC"},   out_valC,        64'h0);
    chk({tag, ".valP"},   out_valP,        64'h0);
    chk({tag, ".valA"},   out_valA,        64'h0);
    chk({tag, ".valB"},   out_valB,        64'h0);
    chk({tag, ".valid"},  64'(out_valid),  64'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; bubble = 1'b0;
    reset2 = 1'b1; stall2 = 1'b0; bubble2 = 1'b0;
    in_status = 4'h1; in_icode = 4'h0; in_ifun = 4'h6; in_rA = 4'h3; in_rB = 4'h0;
    in_valC = 64'd100; in_valP = 64'd64; in_valA = 64'd10; in_valB = 64'd11;

    // 1: reset state, then a plain load
    step();
    reset = 1'b0;
    chkResetImage("rst");
    chk("rst.stallCnt",  64'(stall_cnt),     64'd0);
    chk("rst.bubbleCnt", 64'(bubble_cnt),    64'd0);
    chk("rst.timeout",   64'(stall_timeout), 64'd0);
    chk("rst.ctrlErr",   64'(ctrl_err),      64'd0);
    step();
    chk("load.status", 64'(out_status), 64'h1);
    chk("load.icode",  64'(out_icode),  64'h0);
    chk("load.ifun",   64'(out_ifun),   64'h6);
    chk("load.rA",     64'(out_rA),     64'h3);
    chk("load.rB",     64'(out_rB),     64'h0);
    chk("load.valC",   out_valC,        64'd100);
    chk("load.valP",   out_valP,        64'd64);
    chk("load.valA",   out_valA,        64'd10);
    chk("load.valB",   out_valB,        64'd11);
    chk("load.valid",  64'(out_valid),  64'd1);

    // 2: stall three cycles while inputs change
    stall = 1'b1; in_valA = 64'd99;
    step(); step(); step();
    chk("stall.valA",     out_valA,        64'd10);
    chk("stall.valid",    64'(out_valid),  64'd1);
    chk("stall.stallCnt", 64'(stall_cnt),  64'd3);
    stall = 1'b0;
    step();
    chk("release.valA",     out_valA,       64'd99);
    chk("release.stallCnt", 64'(stall_cnt), 64'd3);

    // 3: single bubble
    bubble = 1'b1;
    step();
    bubble = 1'b0;
    chkResetImage("bub");
    chk("bub.bubbleCnt", 64'(bubble_cnt), 64'd1);
    chk("bub.ctrlErr",   64'(ctrl_err),   64'd0);

    // 4: stall and bubble together
    stall = 1'b1; bubble = 1'b1;
    step();
    stall = 1'b0; bubble = 1'b0;
    chkResetImage("both");
    chk("both.ctrlErr",   64'(ctrl_err),   64'd1);
    chk("both.stallCnt",  64'(stall_cnt),  64'd3);
    chk("both.bubbleCnt", 64'(bubble_cnt), 64'd2);
    step();
    chk("both.sticky",   64'(ctrl_err),  64'd1);
    chk("both.reload",   64'(out_valid), 64'd1);

    // 5: stall watchdog, 7 / drop / 7 then 8th edge
    stall = 1'b1;
    repeat (7) step();
    chk("wd.run7",   64'(stall_timeout), 64'd0);
    stall = 1'b0;
    step();
    chk("wd.drop",   64'(stall_timeout), 64'd0);
    stall = 1'b1;
    repeat (7) step();
    chk("wd.run2_7", 64'(stall_timeout), 64'd0);
    step();
    chk("wd.run2_8", 64'(stall_timeout), 64'd1);
    chk("wd.stallCnt", 64'(stall_cnt), 64'd18);
    stall = 1'b0;
    in_status = 4'h3; in_icode = 4'h7;
    step();
    chk("wd.sticky",  64'(stall_timeout), 64'd1);
    chk("adr.status", 64'(out_status),    64'h3);
    chk("adr.icode",  64'(out_icode),     64'h7);

    // 6a: reset while stalling discards everything
    stall = 1'b1; reset = 1'b1;
    step();
    stall = 1'b0; reset = 1'b0;
    chkResetImage("rstStall");
    chk("rstStall.stallCnt",  64'(stall_cnt),     64'd0);
    chk("rstStall.bubbleCnt", 64'(bubble_cnt),    64'd0);
    chk("rstStall.timeout",   64'(stall_timeout), 64'd0);
    chk("rstStall.ctrlErr",   64'(ctrl_err),      64'd0);

    // 6b: 2-bit bubble counter saturates
    reset2 = 1'b0; bubble2 = 1'b1;
    step(); step();
    chk("sat.cnt2", 64'(o2BubbleCnt), 64'd2);
    step();
    chk("sat.cnt3", 64'(o2BubbleCnt), 64'd3);
    step(); step();
    chk("sat.cnt5", 64'(o2BubbleCnt), 64'd3);
    chk("sat.valid", 64'(o2Valid),    64'd0);
    bubble2 = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
